// File: rtl/sync_deskew_bram.sv
// Two-stream sync deskewer: measures the sync offset between streams A and B and
// delays the leading stream through a circular buffer so both leave sync-aligned.
module sync_deskew_bram #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_SKEW   = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [WIDTH-1:0]      din_a,
    input  logic                  sync_a,
    input  logic [WIDTH-1:0]      din_b,
    input  logic                  sync_b,
    output logic [WIDTH-1:0]      dout_a,
    output logic [WIDTH-1:0]      dout_b,
    output logic                  sync_out,
    output logic                  locked,
    output logic [ADDR_WIDTH-1:0] skew,
    output logic                  a_leads,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_SKEW_W = (ADDR_WIDTH + 1)'(MAX_SKEW);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t                state_reg, state_next;
    logic                  leader_a_reg, leader_a_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  pending_reg, pending_next;
    logic [ADDR_WIDTH-1:0] skew_reg, skew_next;
    logic                  a_leads_reg, a_leads_next;
    logic [ADDR_WIDTH-1:0] delay_a_reg, delay_a_next;
    logic [ADDR_WIDTH-1:0] delay_b_reg, delay_b_next;
    logic                  locked_reg, locked_next;
    logic                  err_reg, err_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;

    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  lead_sync;
    logic                  lag_sync;
    logic                  mismatch;

    assign cnt_inc   = {1'b0, cnt_reg} + (ADDR_WIDTH + 1)'(1);
    assign lead_sync = leader_a_reg ? sync_a : sync_b;
    assign lag_sync  = leader_a_reg ? sync_b : sync_a;

    // ------------------------------------------------------------------
    // Delay lines
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]      din_s   [2];
    logic [WIDTH-1:0]      dout_s  [2];
    logic [ADDR_WIDTH-1:0] delay_s [2];
    logic [1:0]            sync_s;
    logic                  sync_b_d;

    assign din_s[0]   = din_a;
    assign din_s[1]   = din_b;
    assign sync_s     = {sync_b, sync_a};
    assign delay_s[0] = delay_a_reg;
    assign delay_s[1] = delay_b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
        end else if (ce) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stream
            // Only stream B's delayed sync is consumed, so only B's buffer carries it.
            localparam int MW = WIDTH + gi;

            logic [MW-1:0]         buf_mem [DEPTH];
            logic [MW-1:0]         wdata;
            logic [MW-1:0]         out_reg;
            logic [ADDR_WIDTH-1:0] rd_addr;

            assign wdata   = MW'({sync_s[gi], din_s[gi]});
            assign rd_addr = wr_ptr_reg - delay_s[gi];

            always_ff @(posedge clk) begin
                if (ce) begin
                    buf_mem[wr_ptr_reg] <= wdata;
                end
            end

            // Zero delay bypasses the array so a same-address read never happens.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_reg <= '0;
                end else if (ce) begin
                    out_reg <= (delay_s[gi] == '0) ? wdata : buf_mem[rd_addr];
                end
            end

            assign dout_s[gi] = out_reg[WIDTH-1:0];

            if (gi == 1) begin : g_sync
                assign sync_b_d = out_reg[MW-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Skew measurement / lock tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= SEARCH;
            leader_a_reg <= 1'b0;
            cnt_reg      <= '0;
            pending_reg  <= 1'b0;
            skew_reg     <= '0;
            a_leads_reg  <= 1'b0;
            delay_a_reg  <= '0;
            delay_b_reg  <= '0;
            locked_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else if (ce) begin
            state_reg    <= state_next;
            leader_a_reg <= leader_a_next;
            cnt_reg      <= cnt_next;
            pending_reg  <= pending_next;
            skew_reg     <= skew_next;
            a_leads_reg  <= a_leads_next;
            delay_a_reg  <= delay_a_next;
            delay_b_reg  <= delay_b_next;
            locked_reg   <= locked_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        leader_a_next = leader_a_reg;
        cnt_next      = cnt_reg;
        pending_next  = pending_reg;
        skew_next     = skew_reg;
        a_leads_next  = a_leads_reg;
        delay_a_next  = delay_a_reg;
        delay_b_next  = delay_b_reg;
        locked_next   = locked_reg;
        err_next      = 1'b0;
        mismatch      = 1'b0;

        case (state_reg)
            SEARCH: begin
                if (sync_a && sync_b) begin
                    skew_next    = '0;
                    a_leads_next = 1'b0;
                    delay_a_next = '0;
                    delay_b_next = '0;
                    pending_next = 1'b0;
                    locked_next  = 1'b1;
                    state_next   = LOCKED;
                end else if (sync_a || sync_b) begin
                    leader_a_next = sync_a;
                    cnt_next      = '0;
                    state_next    = MEASURE;
                end
            end

            MEASURE: begin
                cnt_next = cnt_inc[ADDR_WIDTH-1:0];
                if (lead_sync || (cnt_inc > MAX_SKEW_W)) begin
                    err_next   = 1'b1;
                    state_next = SEARCH;
                end else if (lag_sync) begin
                    skew_next    = cnt_inc[ADDR_WIDTH-1:0];
                    delay_a_next = leader_a_reg ? cnt_inc[ADDR_WIDTH-1:0] : '0;
                    delay_b_next = leader_a_reg ? '0 : cnt_inc[ADDR_WIDTH-1:0];
                    a_leads_next = leader_a_reg;
                    pending_next = 1'b0;
                    locked_next  = 1'b1;
                    state_next   = LOCKED;
                end
            end

            LOCKED: begin
                if (skew_reg == '0) begin
                    mismatch = sync_a ^ sync_b;
                end else if (pending_reg) begin
                    cnt_next = cnt_inc[ADDR_WIDTH-1:0];
                    if (lead_sync) begin
                        mismatch = 1'b1;
                    end else if (lag_sync || (cnt_inc == {1'b0, skew_reg})) begin
                        // Lagging sync must land exactly on the expected count.
                        if (lag_sync && (cnt_inc == {1'b0, skew_reg})) begin
                            pending_next = 1'b0;
                        end else begin
                            mismatch = 1'b1;
                        end
                    end
                end else if (lag_sync) begin
                    mismatch = 1'b1;
                end else if (lead_sync) begin
                    pending_next = 1'b1;
                    cnt_next     = '0;
                end

                if (mismatch) begin
                    err_next     = 1'b1;
                    locked_next  = 1'b0;
                    pending_next = 1'b0;
                    state_next   = SEARCH;
                end
            end

            default: state_next = SEARCH;
        endcase
    end

    assign dout_a   = dout_s[0];
    assign dout_b   = dout_s[1];
    assign sync_out = sync_b_d & locked_reg;
    assign locked   = locked_reg;
    assign skew     = skew_reg;
    assign a_leads  = a_leads_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_sync_deskew_bram.sv
// Directed bench for sync_deskew_bram: stream data is a cycle counter, so every
// expected output value follows directly from the cycle number and the skew.
module tb_sync_deskew_bram;

    localparam int WIDTH      = 64;
    localparam int ADDR_WIDTH = 9;
    localparam int MAX_SKEW   = 500;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ce;
    logic [WIDTH-1:0]      din_a;
    logic                  sync_a;
    logic [WIDTH-1:0]      din_b;
    logic                  sync_b;
    logic [WIDTH-1:0]      dout_a;
    logic [WIDTH-1:0]      dout_b;
    logic                  sync_out;
    logic                  locked;
    logic [ADDR_WIDTH-1:0] skew;
    logic                  a_leads;
    logic                  err;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    longint boff    = 0;

    sync_deskew_bram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_SKEW   (MAX_SKEW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .din_a    (din_a),
        .sync_a   (sync_a),
        .din_b    (din_b),
        .sync_b   (sync_b),
        .dout_a   (dout_a),
        .dout_b   (dout_b),
        .sync_out (sync_out),
        .locked   (locked),
        .skew     (skew),
        .a_leads  (a_leads),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("[TB] ok   %s = 0x%0h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    // One clock: drive this cycle's inputs, take the edge, sample 1 time unit later.
    task automatic tick(input logic en, input logic sa, input logic sb);
        ce     = en;
        sync_a = sa;
        sync_b = sb;
        din_a  = WIDTH'(cyc);
        din_b  = WIDTH'(cyc - boff);
        @(posedge clk);
        #1;
        if (en) cyc++;
        sync_a = 1'b0;
        sync_b = 1'b0;
    endtask

    task automatic run_to(input longint t);
        while (cyc < t) tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; sync_a = 1'b0; sync_b = 1'b0;
        din_a = '0; din_b = '0;

        // Reset state and delay-0 pass-through
        boff = 7;
        do_reset();
        check_val("rst_locked",   64'(locked),   64'd0);
        check_val("rst_sync_out", 64'(sync_out), 64'd0);
        check_val("rst_err",      64'(err),      64'd0);
        check_val("rst_skew",     64'(skew),     64'd0);
        check_val("rst_dout_a",   dout_a,        64'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check_val("pass_dout_a", dout_a, 64'(i));
        end
        check_val("idle_locked",   64'(locked),   64'd0);
        check_val("idle_sync_out", 64'(sync_out), 64'd0);
        check_val("idle_err",      64'(err),      64'd0);

        // A leads by 7: sync_a at 10, sync_b at 17
        tick(1'b1, 1'b1, 1'b0);
        check_val("meas_locked", 64'(locked), 64'd0);
        run_to(17);
        tick(1'b1, 1'b0, 1'b1);
        check_val("s7_skew",     64'(skew),     64'd7);
        check_val("s7_a_leads",  64'(a_leads),  64'd1);
        check_val("s7_locked",   64'(locked),   64'd1);
        check_val("s7_sync_out", 64'(sync_out), 64'd1);
        check_val("s7_err",      64'(err),      64'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("s7_sync_drop", 64'(sync_out), 64'd0);
        run_to(30);
        check_val("s7_dout_a", dout_a, 64'd22);
        check_val("s7_dout_b", dout_b, 64'd22);

        // Consistent pair one period later keeps lock
        run_to(1034);
        tick(1'b1, 1'b1, 1'b0);
        run_to(1041);
        tick(1'b1, 1'b0, 1'b1);
        check_val("keep_locked",   64'(locked),   64'd1);
        check_val("keep_err",      64'(err),      64'd0);
        check_val("keep_sync_out", 64'(sync_out), 64'd1);

        // Skew changes to 9: mismatch flagged when sync_b misses count 7
        run_to(2058);
        tick(1'b1, 1'b1, 1'b0);
        run_to(2064);
        tick(1'b1, 1'b0, 1'b0);
        check_val("late_err_early", 64'(err), 64'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("late_err",    64'(err),    64'd1);
        check_val("late_locked", 64'(locked), 64'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("late_err_pulse", 64'(err), 64'd0);
        check_val("hold_dout_a",    dout_a,   64'd2059);
        // Stray sync_b at 2067 opens a B-led measurement that times out
        tick(1'b1, 1'b0, 1'b1);
        run_to(2567);
        tick(1'b1, 1'b0, 1'b0);
        check_val("stray_err_pre", 64'(err), 64'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("stray_err",     64'(err), 64'd1);
        boff = 9;
        run_to(3082);
        tick(1'b1, 1'b1, 1'b0);
        run_to(3091);
        tick(1'b1, 1'b0, 1'b1);
        check_val("s9_locked",  64'(locked),  64'd1);
        check_val("s9_skew",    64'(skew),    64'd9);
        check_val("s9_a_leads", 64'(a_leads), 64'd1);
        run_to(3110);
        check_val("s9_dout_a", dout_a, 64'd3100);
        check_val("s9_dout_b", dout_b, 64'd3100);

        // Zero skew: coincident syncs at 20
        boff = 0;
        do_reset();
        run_to(20);
        tick(1'b1, 1'b1, 1'b1);
        check_val("s0_skew",     64'(skew),     64'd0);
        check_val("s0_a_leads",  64'(a_leads),  64'd0);
        check_val("s0_locked",   64'(locked),   64'd1);
        check_val("s0_sync_out", 64'(sync_out), 64'd1);
        tick(1'b1, 1'b0, 1'b0);
        check_val("s0_sync_drop", 64'(sync_out), 64'd0);
        run_to(30);
        check_val("s0_dout_a", dout_a, 64'd29);
        check_val("s0_dout_b", dout_b, 64'd29);
        run_to(620);
        tick(1'b1, 1'b1, 1'b1);
        check_val("s0_keep_locked", 64'(locked), 64'd1);
        check_val("s0_keep_err",    64'(err),    64'd0);
        run_to(1220);
        tick(1'b1, 1'b1, 1'b0);
        check_val("s0_lone_err",    64'(err),    64'd1);
        check_val("s0_lone_locked", 64'(locked), 64'd0);

        // Measurement timeout: sync_b at 0, sync_a would be at 600
        do_reset();
        tick(1'b1, 1'b0, 1'b1);
        run_to(500);
        tick(1'b1, 1'b0, 1'b0);
        check_val("tmo_err_pre", 64'(err), 64'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("tmo_err",    64'(err),    64'd1);
        check_val("tmo_locked", 64'(locked), 64'd0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("tmo_err_pulse", 64'(err), 64'd0);
        run_to(600);
        tick(1'b1, 1'b1, 1'b0);
        check_val("tmo_relaunch_locked", 64'(locked), 64'd0);

        // ce at 50%: skew counts enabled cycles only; gated sync_b ignored
        do_reset();
        tick(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, k == 3);
            if (k == 3) check_val("ce_gated_locked", 64'(locked), 64'd0);
            tick(1'b1, 1'b0, k == 5);
        end
        check_val("ce_skew",    64'(skew),    64'd5);
        check_val("ce_a_leads", 64'(a_leads), 64'd1);
        check_val("ce_locked",  64'(locked),  64'd1);
        check_val("ce_sync_out", 64'(sync_out), 64'd1);
        run_to(cyc + 10);

        // Reset while locked
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        check_val("mid_rst_locked",  64'(locked),   64'd0);
        check_val("mid_rst_skew",    64'(skew),     64'd0);
        check_val("mid_rst_a_leads", 64'(a_leads),  64'd0);
        check_val("mid_rst_sync",    64'(sync_out), 64'd0);
        check_val("mid_rst_err",     64'(err),      64'd0);
        check_val("mid_rst_dout_a",  dout_a,        64'd0);
        check_val("mid_rst_dout_b",  dout_b,        64'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_deskew_bram.md
Name: sync_deskew_bram

Overview:
- Two-stream skew remover built on a circular-buffer delay line.
- Measures the offset between the sync pulses of stream A and stream B, then delays the leading stream by that offset so both streams leave with their syncs aligned.
- Sits after per-input capture logic, ahead of correlator/beamformer stages that need sync-aligned inputs.
- Tracks lock continuously; relocks after a sync mismatch.

Parameters:
- WIDTH, 64, data width of each stream in bits.
- ADDR_WIDTH, 9, buffer address width; buffer depth is 2^ADDR_WIDTH words per stream.
- MAX_SKEW, 500, largest correctable skew in ce cycles; must be <= 2^ADDR_WIDTH-2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- ce  input  1  clock enable; no state advances while low.
- din_a  input  WIDTH  stream A data.
- sync_a  input  1  stream A sync pulse, one ce cycle wide.
- din_b  input  WIDTH  stream B data.
- sync_b  input  1  stream B sync pulse.
- dout_a  output  WIDTH  aligned stream A.
- dout_b  output  WIDTH  aligned stream B.
- sync_out  output  1  aligned sync; only asserted while locked.
- locked  output  1  high while the alignment is valid.
- skew  output  ADDR_WIDTH  measured skew magnitude.
- a_leads  output  1  1 means A is delayed; 0 means B is delayed, or skew is 0.
- err  output  1  one-cycle pulse on a measurement failure or loss of lock.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0; state SEARCH; delay_a = delay_b = 0; write pointer 0; counter 0.
- ce gating:
  - All pointers, counters, FSM state and output registers update only on clk edges with ce=1.
  - "Cycle" below means a ce cycle.
- Datapath:
  - Each stream is written to its own buffer at wr_ptr every cycle; wr_ptr increments mod 2^ADDR_WIDTH.
  - dout_x(t) = din_x(t-1-delay_x). Delay 0 is a 1-cycle registered path; no read-before-write hazard is permitted.
  - Read address = wr_ptr - delay_x, mod 2^ADDR_WIDTH.
- Delayed syncs: sync_a and sync_b pass through the same delays as their data. sync_out = delayed sync_b AND locked.
- FSM states: SEARCH, MEASURE, LOCKED.
- SEARCH:
  - sync_a and sync_b in the same cycle: skew=0, a_leads=0, both delays 0, go to LOCKED.
  - sync_a alone: leader=A, cnt=0, go to MEASURE.
  - sync_b alone: leader=B, cnt=0, go to MEASURE.
- MEASURE:
  - cnt increments each cycle.
  - Lagging sync arrives: skew=cnt+1, the leader's delay becomes skew, the other delay becomes 0, a_leads=(leader==A), go to LOCKED.
  - Leader sync arrives again, or cnt+1 > MAX_SKEW: err pulse, go to SEARCH with delays unchanged.
- Delay changes:
  - A new delay takes effect on the cycle after it is loaded.
  - locked rises in the same cycle the new delays are applied.
  - Output data from the first skew cycles after lock may contain stale buffer contents; this is accepted.
- LOCKED (sync period must exceed MAX_SKEW):
  - Leader sync starts a check counter.
  - The lagging sync must arrive exactly skew cycles later.
  - For skew=0, the two syncs must coincide.
  - Any of the following is a mismatch: early or late lagging sync, a lagging sync with no pending leader, or a second leader sync while a check is pending.
  - On a mismatch: err pulse, locked=0 the next cycle, go to SEARCH.
  - On a mismatch, delays hold their values until the next lock.
  - A mismatching sync does not itself start a new SEARCH measurement; the next fresh sync does.
- Not locked: sync_out=0; dout continues using the last delays.
- rst mid-operation returns the block to its reset state on the next edge regardless of FSM state.

Test Plan:
- Reset, then constant counting data with no syncs -> dout_a = din_a delayed 1, locked=0, sync_out=0, err=0.
- sync_a at cycle 10, sync_b at cycle 17, period 1024 -> skew=7, a_leads=1, locked=1; sync_out at cycle 18; dout_a equals dout_b when din_b = din_a delayed 7.
- sync_b at 20, sync_a at 20 -> skew=0, a_leads=0, locked=1; sync_out at 21.
- MAX_SKEW=500, sync_b at 0, sync_a at 600 -> err pulse at cycle 501, state SEARCH, locked=0.
- Locked at skew 7, then a later pair with skew 9 -> err pulse, locked falls; the next consistent pair at skew 9 relocks with skew=9.
- ce toggled 50% during a skew-5 measurement -> skew counts ce cycles only (5); rst asserted in LOCKED -> all outputs 0 next cycle.
